// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store unit with sub-word extension and read-modify-write stores
module load_store_unit #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        addr_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        addr_error_q, addr_error_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        req_error;

  // Lanes are big-endian: offset 0 is the most significant byte/half.
  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (off[1]) r[15:0] = d[15:0];
      else        r[31:16] = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  always_comb begin
    req_error = (size == 2'b11)
             || ((size == 2'b01) && addr[0])
             || ((size == 2'b10) && (addr[1:0] != 2'b00))
             || (addr[31:2] >= DEPTH_W);
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    sdata_d      = sdata_q;
    load_data_d  = load_data_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = 1'b0;
    addr_error_d = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d       = we;
          size_d     = size;
          uns_d      = unsigned_ld;
          off_d      = addr[1:0];
          sdata_d    = store_data;
          mem_addr_d = {2'b00, addr[31:2]};
          if (req_error) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            addr_error_d = 1'b1;
          end else if (!we) begin
            state_d    = S_LOAD;
            mem_read_d = 1'b1;
          end else if (size == 2'b10) begin
            state_d     = S_WRITE;
            mem_write_d = 1'b1;
            mem_wdata_d = store_data;
          end else begin
            state_d    = S_RMW_READ;
            mem_read_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        load_data_d = extend_load(mem_rdata, size_q, off_q, uns_q);
        state_d     = S_DONE;
        done_d      = 1'b1;
      end
      S_RMW_READ: begin
        mem_wdata_d = merge_store(mem_rdata, sdata_q, size_q, off_q);
        mem_write_d = 1'b1;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      sdata_q      <= 32'h0;
      load_data_q  <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_error_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      sdata_q      <= sdata_d;
      load_data_q  <= load_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      addr_error_q <= addr_error_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  // we_q is kept with the other request fields; the store path is chosen at acceptance.
  logic unused_we;
  assign unused_we  = we_q;

  assign load_data  = load_data_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign addr_error = addr_error_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        addr_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem_arr [0:31];

  int passed = 0;
  int total  = 0;

  int          r_done_cyc, r_read_cyc, r_write_cyc, r_reads, r_writes;
  logic        r_err, r_addr_bad, r_both, r_busy1;
  logic [31:0] r_wdata, r_ld;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .unsigned_ld(unsigned_ld),
    .addr(addr), .store_data(store_data), .load_data(load_data), .busy(busy), .done(done),
    .addr_error(addr_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'd32) ? mem_arr[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && mem_addr < 32'd32) mem_arr[mem_addr[4:0]] <= mem_wdata;
  end

  task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = a; store_data = d;
    r_done_cyc = 0; r_read_cyc = 0; r_write_cyc = 0; r_reads = 0; r_writes = 0;
    r_err = 1'b0; r_addr_bad = 1'b0; r_both = 1'b0; r_busy1 = 1'b0;
    r_wdata = 32'h0; r_ld = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) r_busy1 = busy;
      if (mem_read && mem_write) r_both = 1'b1;
      if (mem_read) begin
        r_reads++;
        if (r_read_cyc == 0) r_read_cyc = k;
      end
      if (mem_write) begin
        r_writes++;
        r_write_cyc = k;
        r_wdata = mem_wdata;
      end
      if ((mem_read || mem_write) && mem_addr !== {2'b00, a[31:2]}) r_addr_bad = 1'b1;
      if (!done && addr_error) r_err = 1'bx;
      if (done) begin
        r_done_cyc = k;
        r_err = addr_error;
        r_ld = load_data;
        break;
      end
    end
    req = 1'b0;
    total++;
    if (r_done_cyc == 0) $display("FAIL timeout addr=%h: no done within 8 cycles", a);
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    addr = 32'h0; store_data = 32'h0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, addr_error, mem_read, mem_write} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {busy, done, addr_error, mem_read, mem_write});
    else passed++;
    total++;
    if ({load_data, mem_addr, mem_wdata} !== 96'h0)
      $display("FAIL reset_buses got %h/%h/%h want 0", load_data, mem_addr, mem_wdata);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_word_round_trip;
    run_op(1'b1, 2'b10, 1'b0, 32'h0000000C, 32'hDEADBEEF);
    total++;
    if (r_write_cyc != 1 || r_writes != 1 || r_reads != 0 || r_done_cyc != 2)
      $display("FAIL sw_timing got wr=%0d nwr=%0d nrd=%0d done=%0d want 1 1 0 2",
               r_write_cyc, r_writes, r_reads, r_done_cyc);
    else passed++;
    total++;
    if (r_wdata !== 32'hDEADBEEF || r_addr_bad || r_err !== 1'b0 || r_busy1 !== 1'b1)
      $display("FAIL sw_data got wdata=%h addr_bad=%b err=%b busy=%b want deadbeef 0 0 1",
               r_wdata, r_addr_bad, r_err, r_busy1);
    else passed++;
    run_op(1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0);
    total++;
    if (r_read_cyc != 1 || r_writes != 0 || r_done_cyc != 2 || r_ld !== 32'hDEADBEEF || r_both)
      $display("FAIL lw_trip got rd=%0d nwr=%0d done=%0d data=%h want 1 0 2 deadbeef",
               r_read_cyc, r_writes, r_done_cyc, r_ld);
    else passed++;
  endtask

  task automatic test_sub_word_loads;
    logic [31:0] la [5];
    logic [1:0]  ls [5];
    logic        lu [5];
    logic [31:0] le [5];
    la = '{32'h4, 32'h4, 32'h6, 32'h6, 32'h4};
    ls = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    lu = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    le = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'h00007F01, 32'h000080FF};
    run_op(1'b1, 2'b10, 1'b0, 32'h4, 32'h80FF7F01);
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, ls[i], lu[i], la[i], 32'h0);
      total++;
      if (r_ld !== le[i] || r_done_cyc != 2 || r_err !== 1'b0)
        $display("FAIL subload_%0d got %h done=%0d want %h done=2", i, r_ld, r_done_cyc, le[i]);
      else passed++;
    end
  endtask

  task automatic test_rmw_stores;
    run_op(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344);
    run_op(1'b1, 2'b00, 1'b0, 32'h16, 32'h000000AB);
    total++;
    if (r_reads != 1 || r_read_cyc != 1 || r_write_cyc != 2 || r_done_cyc != 3 || r_both || r_addr_bad)
      $display("FAIL sb_timing got rd=%0d/%0d wr=%0d done=%0d want 1/1 2 3",
               r_reads, r_read_cyc, r_write_cyc, r_done_cyc);
    else passed++;
    total++;
    if (r_wdata !== 32'h1122AB44) $display("FAIL sb_merge got %h want 1122ab44", r_wdata);
    else passed++;
    run_op(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    total++;
    if (r_ld !== 32'h1122AB44) $display("FAIL sb_readback got %h want 1122ab44", r_ld);
    else passed++;
    run_op(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344);
    run_op(1'b1, 2'b01, 1'b0, 32'h14, 32'h1234CAFE);
    total++;
    if (r_wdata !== 32'hCAFE3344 || r_done_cyc != 3)
      $display("FAIL sh_merge got %h done=%0d want cafe3344 done=3", r_wdata, r_done_cyc);
    else passed++;
  endtask

  task automatic test_errors;
    logic        ew [4];
    logic [1:0]  es [4];
    logic [31:0] ea [4];
    ew = '{1'b0, 1'b1, 1'b0, 1'b0};
    es = '{2'b10, 2'b01, 2'b11, 2'b10};
    ea = '{32'h2, 32'h3, 32'h0, 32'h80};
    run_op(1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0);
    for (int i = 0; i < 4; i++) begin
      run_op(ew[i], es[i], 1'b0, ea[i], 32'h5555AAAA);
      total++;
      if (r_done_cyc != 1 || r_err !== 1'b1 || r_reads != 0 || r_writes != 0 || r_ld !== 32'hDEADBEEF)
        $display("FAIL err_%0d got done=%0d err=%b rd=%0d wr=%0d ld=%h want 1 1 0 0 deadbeef",
                 i, r_done_cyc, r_err, r_reads, r_writes, r_ld);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_rmw;
    run_op(1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; unsigned_ld = 1'b0; addr = 32'h8; store_data = 32'h55;
    @(negedge clk);
    total++;
    if (mem_read !== 1'b1 || busy !== 1'b1)
      $display("FAIL rmw_read_entry got rd=%b busy=%b want 1 1", mem_read, busy);
    else passed++;
    rst = 1'b1;
    req = 1'b0;
    #1;
    total++;
    if ({busy, done, addr_error, mem_read, mem_write} !== 5'b0 || {load_data, mem_addr, mem_wdata} !== 96'h0)
      $display("FAIL rst_mid_rmw got flags=%b ld=%h ma=%h wd=%h want all 0",
               {busy, done, addr_error, mem_read, mem_write}, load_data, mem_addr, mem_wdata);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    total++;
    if (r_ld !== 32'h12345678 || r_done_cyc != 2)
      $display("FAIL rst_word2 got %h done=%0d want 12345678 done=2", r_ld, r_done_cyc);
    else passed++;
  endtask

  task automatic test_back_to_back;
    run_op(1'b0, 2'b00, 1'b1, 32'h17, 32'h0);
    total++;
    if (r_ld !== 32'h00000044) $display("FAIL b2b_lbu got %h want 00000044", r_ld);
    else passed++;
    run_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    total++;
    if (r_ld !== 32'h00000000 && r_ld !== 32'hXXXXXXXX && r_done_cyc != 2)
      $display("FAIL b2b_lh done=%0d want 2", r_done_cyc);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_word_round_trip;
    test_sub_word_loads;
    test_rmw_stores;
    test_errors;
    test_reset_mid_rmw;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
